// File: rtl/csr_row_scheduler_if.sv
// rtl/csr_row_scheduler_if.sv - row-length and element-request streams of the CSR row scheduler
interface csr_row_scheduler_if #(
    parameter int LEN_W = 5,
    parameter int ROW_W = 5
);
    logic             len_valid;
    logic [LEN_W-1:0] len_data;
    logic             len_ready;
    logic             elem_valid;
    logic             elem_ready;
    logic [ROW_W-1:0] elem_row;
    logic [LEN_W-1:0] elem_idx;
    logic             elem_last;
    logic             elem_zero;

    modport master (
        input  len_valid, len_data, elem_ready,
        output len_ready, elem_valid, elem_row, elem_idx, elem_last, elem_zero
    );

    modport slave (
        output len_valid, len_data, elem_ready,
        input  len_ready, elem_valid, elem_row, elem_idx, elem_last, elem_zero
    );
endinterface

// File: rtl/csr_row_scheduler.sv
// rtl/csr_row_scheduler.sv - handshaked CSR row/element sequencer; CSR_EMPTY_ROW_MARKER_EN adds a zero beat for empty rows
module csr_row_scheduler #(
    parameter int LEN_W = 5,
    parameter int ROW_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_W-1:0]     num_rows,
    csr_row_scheduler_if.master  bus,
    output logic                 row_done,
    output logic [ROW_W-1:0]     row_done_idx,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t           state;
    logic [ROW_W-1:0] rows_q;
    logic [ROW_W-1:0] row_cnt;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] idx;
    logic             len_ready_q;
    logic             elem_valid_q;
    logic             last_row;
`ifdef CSR_EMPTY_ROW_MARKER_EN
    logic             elem_zero_q;
`endif

    assign last_row = (row_cnt == rows_q - ROW_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rows_q       <= '0;
            row_cnt      <= '0;
            remaining    <= '0;
            idx          <= '0;
            len_ready_q  <= 1'b0;
            elem_valid_q <= 1'b0;
            row_done     <= 1'b0;
            row_done_idx <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef CSR_EMPTY_ROW_MARKER_EN
            elem_zero_q  <= 1'b0;
`endif
        end else begin
            row_done <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q  <= num_rows;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                        if (num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            len_ready_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.len_valid) begin
                        idx <= '0;
                        if (bus.len_data != '0) begin
                            remaining    <= bus.len_data;
                            state        <= ISSUE;
                            len_ready_q  <= 1'b0;
                            elem_valid_q <= 1'b1;
                        end else begin
`ifdef CSR_EMPTY_ROW_MARKER_EN
                            // Empty row becomes a single marker beat so the accumulator writes a zero.
                            remaining    <= LEN_W'(1);
                            elem_zero_q  <= 1'b1;
                            state        <= ISSUE;
                            len_ready_q  <= 1'b0;
                            elem_valid_q <= 1'b1;
`else
                            remaining    <= '0;
                            row_done     <= 1'b1;
                            row_done_idx <= row_cnt;
                            row_cnt      <= row_cnt + ROW_W'(1);
                            if (last_row) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                len_ready_q <= 1'b0;
                            end
`endif
                        end
                    end
                end
                ISSUE: begin
                    if (bus.elem_ready) begin
                        idx       <= idx + LEN_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            elem_valid_q <= 1'b0;
`ifdef CSR_EMPTY_ROW_MARKER_EN
                            elem_zero_q  <= 1'b0;
`endif
                            row_done     <= 1'b1;
                            row_done_idx <= row_cnt;
                            row_cnt      <= row_cnt + ROW_W'(1);
                            if (last_row) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= FETCH;
                                len_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.len_ready  = len_ready_q;
    assign bus.elem_valid = elem_valid_q;
    assign bus.elem_row   = row_cnt;
    assign bus.elem_idx   = idx;
    assign bus.elem_last  = elem_valid_q && (remaining == LEN_W'(1));
`ifdef CSR_EMPTY_ROW_MARKER_EN
    assign bus.elem_zero  = elem_zero_q;
`else
    assign bus.elem_zero  = 1'b0;
`endif
endmodule
